// File: rtl/usb_pio_pkg.sv
// usb_pio shared definitions: register word addresses
// and the pulse state type.
package usb_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_EDGE   = 3'd2;
  localparam logic [2:0] ADDR_SET    = 3'd3;
  localparam logic [2:0] ADDR_CLR    = 3'd4;
  localparam logic [2:0] ADDR_PLEN   = 3'd5;
  localparam logic [2:0] ADDR_PTRIG  = 3'd6;
  localparam logic [2:0] ADDR_STATUS = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } pulse_st_t;

endpackage

// File: rtl/usb_pio_if.sv
// usb_pio register bus: address, chipselect, write_n,
// writedata (master->slave), readdata (slave->master).
interface usb_pio_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/usb_pio_sync.sv
// 2-flop input synchroniser plus rising-edge detect.
// Ports: clk, reset_n, i_async in; o_sync, o_rise out.
module usb_pio_sync #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] i_async,
  output logic [DATA_W-1:0] o_sync,
  output logic [DATA_W-1:0] o_rise
);

  logic [DATA_W-1:0] r_s1;
  logic [DATA_W-1:0] r_s2;
  logic [DATA_W-1:0] r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // r_prev seeded 0: an input already high at reset
  // yields exactly one edge once it is synchronised.
  assign o_sync = r_s2;
  assign o_rise = r_s2 & ~r_prev;

endmodule

// File: rtl/usb_pio.sv
// Parallel I/O with edge capture, irq and timed pulses.
// Ports: clk, reset_n, bus (slave), in_port, out_port, irq.
module usb_pio
  import usb_pio_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              PULSE_W   = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  usb_pio_if.slave          bus,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              irq
);

  logic [DATA_W-1:0]  r_out;
  logic [DATA_W-1:0]  r_mask;
  logic [DATA_W-1:0]  r_edge;
  logic [DATA_W-1:0]  r_pmask;
  logic [PULSE_W-1:0] r_plen;
  logic [PULSE_W-1:0] r_cnt;
  pulse_st_t          r_state;

  logic [DATA_W-1:0]  w_sync;
  logic [DATA_W-1:0]  w_rise;
  logic [DATA_W-1:0]  w_wd;
  logic [DATA_W-1:0]  w_eclr;
  logic [DATA_W-1:0]  w_out_base;
  logic [DATA_W-1:0]  w_pm_base;
  logic [31:0]        w_rd;
  logic [31:0]        w_stat;
  logic               w_wr;
  logic               w_end;
  logic               w_sel_data;
  logic               w_sel_set;
  logic               w_sel_clr;
  logic               w_trig;
  logic               w_unused;

  usb_pio_sync #(.DATA_W(DATA_W)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (in_port),
    .o_sync  (w_sync),
    .o_rise  (w_rise)
  );

  assign w_wr   = bus.chipselect & ~bus.write_n;
  assign w_wd   = bus.writedata[DATA_W-1:0];
  assign w_unused = &{1'b0, bus.writedata};

  assign w_sel_data = w_wr && (bus.address == ADDR_DATA);
  assign w_sel_set  = w_wr && (bus.address == ADDR_SET);
  assign w_sel_clr  = w_wr && (bus.address == ADDR_CLR);
  assign w_trig     = w_wr && (bus.address == ADDR_PTRIG)
                      && (|w_wd);

  assign w_end = (r_state == ST_PULSE)
                 && (r_cnt <= PULSE_W'(1));

  // Pulse-end clear is applied first; a same-cycle
  // register write then acts on the cleared value.
  assign w_out_base = w_end ? (r_out & ~r_pmask) : r_out;
  assign w_pm_base  = w_end ? '0 : r_pmask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out   <= RESET_VAL;
      r_pmask <= '0;
      r_cnt   <= '0;
      r_state <= ST_IDLE;
    end else begin
      r_out   <= w_out_base;
      r_pmask <= w_pm_base;
      unique case (r_state)
        ST_IDLE: r_cnt <= r_cnt;
        ST_PULSE: begin
          if (w_end) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      endcase
      unique case (1'b1)
        w_sel_data: r_out <= w_wd;
        w_sel_set:  r_out <= w_out_base | w_wd;
        w_sel_clr:  r_out <= w_out_base & ~w_wd;
        w_trig: begin
          r_out   <= w_out_base | w_wd;
          r_pmask <= w_pm_base | w_wd;
          r_cnt   <= r_plen;
          r_state <= ST_PULSE;
        end
        default: ;
      endcase
    end
  end

  assign w_eclr = (w_wr && bus.address == ADDR_EDGE)
                  ? w_wd : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_edge <= '0;
      r_plen <= '0;
    end else begin
      // A new edge wins over a same-cycle clear.
      r_edge <= (r_edge & ~w_eclr) | w_rise;
      if (w_wr && bus.address == ADDR_MASK)
        r_mask <= w_wd;
      if (w_wr && bus.address == ADDR_PLEN)
        r_plen <= bus.writedata[PULSE_W-1:0];
    end
  end

  assign w_stat = (32'(r_cnt) << 8)
                  | {31'd0, r_state == ST_PULSE};

  always_comb begin
    w_rd = '0;
    unique case (bus.address)
      ADDR_DATA:   w_rd = 32'(w_sync);
      ADDR_MASK:   w_rd = 32'(r_mask);
      ADDR_EDGE:   w_rd = 32'(r_edge);
      ADDR_SET:    w_rd = 32'(r_out);
      ADDR_CLR:    w_rd = 32'(r_out);
      ADDR_PLEN:   w_rd = 32'(r_plen);
      ADDR_PTRIG:  w_rd = '0;
      ADDR_STATUS: w_rd = w_stat;
    endcase
  end

  assign bus.readdata = w_rd;
  assign out_port     = r_out;
  assign irq          = |(r_edge & r_mask);

endmodule

// File: doc/usb_pio.md
USB_PIO -- requirements
Module: usb_pio

Interface
REQ-001 SHALL have parameter DATA_W, default 8, port width in bits (legal 1..32).
REQ-002 SHALL have parameter PULSE_W, default 16, pulse-length counter width in bits (legal 1..32).
REQ-003 SHALL have parameter RESET_VAL, default 0, out_port value after reset.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port address  input  3  register word select.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  write strobe, active-low, qualified by chipselect.
REQ-009 SHALL have port writedata  input  32  write data; only low DATA_W (PULSE_W for PLEN) bits used.
REQ-010 SHALL have port readdata  output  32  combinational read data; unused upper bits 0.
REQ-011 SHALL have port in_port  input  DATA_W  asynchronous external inputs.
REQ-012 SHALL have port out_port  output  DATA_W  registered outputs.
REQ-013 SHALL have port irq  output  1  level interrupt, active-high.

Function
REQ-014 SHALL decode a write as chipselect=1 and write_n=0; register effect visible one cycle after the write edge.
REQ-015 SHALL map: 0 DATA, 1 MASK, 2 EDGE, 3 SET, 4 CLR, 5 PLEN, 6 PTRIG, 7 STATUS.
REQ-016 DATA write SHALL load out_reg; DATA read SHALL return the synchronised in_port value.
REQ-017 SET write SHALL perform out_reg |= wdata; CLR write SHALL perform out_reg &= ~wdata; reads of 3 and 4 SHALL return out_reg.
REQ-018 in_port SHALL pass through a 2-flop synchroniser; a rising edge SHALL be detected from the last two synchronised samples.
REQ-019 A detected rising edge on bit i SHALL set EDGE[i]; an EDGE write with bit i=1 SHALL clear EDGE[i]; reads SHALL have no side effect.
REQ-020 A new edge and a clear on the same bit in the same cycle SHALL leave the bit set.
REQ-021 irq SHALL equal |(EDGE & MASK), registered-free (combinational from the registers).
REQ-022 PLEN SHALL hold pulse length L (PULSE_W bits), read/write.
REQ-023 The pulse FSM SHALL have states IDLE and PULSE.
REQ-024 A PTRIG write with nonzero data SHALL: OR data into out_reg and into pulse_mask, load cnt with L, and enter PULSE.
REQ-025 In PULSE, cnt SHALL decrement each cycle; at an edge where cnt<=1, out_reg &= ~pulse_mask, pulse_mask SHALL clear, and the FSM SHALL enter IDLE.
REQ-026 Pulsed bits SHALL therefore be high for max(L,1) cycles.
REQ-027 A PTRIG write during PULSE SHALL OR the new bits in and reload cnt with L (retrigger).
REQ-028 A PTRIG write of zero SHALL be ignored.
REQ-029 DATA, SET or CLR writes during PULSE SHALL apply normally; pulse end SHALL clear only pulse_mask bits.
REQ-030 Priority for out_reg in one cycle SHALL be: pulse-end clear, then the register write.
REQ-031 STATUS read SHALL return {cnt in bits [PULSE_W+7:8]... truncated to 32, busy in bit 0}, where busy=1 in PULSE.
REQ-032 Unmapped write data bits SHALL be ignored.

Reset
REQ-033 On reset_n=0, asynchronously: out_reg=RESET_VAL, MASK=0, EDGE=0, PLEN=0, cnt=0, pulse_mask=0, FSM=IDLE, synchroniser flops=0.
REQ-034 Reset asserted mid-pulse SHALL abort the pulse with no end-clear beyond REQ-033.
REQ-035 The first cycle after reset SHALL NOT report an edge for inputs already high (edge detector seeded 0 then requires a 0->1 of synchronised samples; a high input after reset SHALL produce exactly one edge).

Structure
REQ-036 Package usb_pio_pkg SHALL hold the register address constants and the FSM state type.
REQ-037 Sub-module usb_pio_sync SHALL implement the 2-flop synchroniser plus rising-edge detect, width DATA_W.

Verification
REQ-038 DATA write 0xA5 -> out_port=0xA5 next cycle; SET 0x0A -> 0xAF; CLR 0x05 -> 0xAA.
REQ-039 in_port[3] 0->1 -> EDGE[3]=1 three cycles later; MASK=0x08 -> irq=1; EDGE write 0x08 -> irq=0.
REQ-040 PLEN=4, PTRIG=0x01 from out=0 -> out_port[0]=1 for exactly 4 cycles; PLEN=0 -> 1 cycle.
REQ-041 PLEN=10, PTRIG=0x01, PTRIG=0x02 after 5 cycles -> both bits clear together 10 cycles after second write.
REQ-042 Edge and EDGE-clear on same bit same cycle -> bit remains 1.
REQ-043 reset_n low mid-pulse with RESET_VAL=0x3C -> out_port=0x3C immediately, STATUS busy=0.
